serial_mag_comp: RTL and testbench

//   Bit-serial, MSB-first magnitude comparator; sequential counterpart of the 2-bit parallel comparator.

---
 rtl/serial_mag_comp.sv | 102 ++++++++++
 tb/tb_serial_mag_comp.sv | 132 +++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: bit-serial MSB-first magnitude comparator with a valid/ready handshake on both sides
// and saturating tallies of the acknowledged outcomes.
module serial_mag_comp #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic {RECV, HOLD} state_t;
  typedef enum logic [1:0] {D_EQ, D_GT, D_LT} dec_t;
  state_t state_q, state_d;
  dec_t dec_q, dec_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d, cnt_eq_q, cnt_eq_d, cnt_lt_q, cnt_lt_d;
  logic in_ready_q, in_ready_d, res_valid_q, res_valid_d;
  logic gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic acc, ack, last;
  assign acc  = (state_q == RECV) && in_valid;
  assign ack  = (state_q == HOLD) && res_ready;
  assign last = bit_q == CW'(WIDTH - 1);
  always_comb begin
    state_d  = state_q;
    dec_d    = dec_q;
    bit_d    = bit_q;
    cnt_gt_d = cnt_gt_q;
    cnt_eq_d = cnt_eq_q;
    cnt_lt_d = cnt_lt_q;
    if (clr) begin
      state_d  = RECV;
      dec_d    = D_EQ;
      bit_d    = '0;
      cnt_gt_d = '0;
      cnt_eq_d = '0;
      cnt_lt_d = '0;
    end else if (acc) begin
      bit_d   = last ? '0 : bit_q + 1'b1;
      dec_d   = (dec_q == D_EQ && in_a != in_b) ? (in_a ? D_GT : D_LT) : dec_q;
      state_d = last ? HOLD : RECV;
    end else if (ack) begin
      cnt_gt_d = (dec_q == D_GT && !(&cnt_gt_q)) ? cnt_gt_q + 1'b1 : cnt_gt_q;
      cnt_eq_d = (dec_q == D_EQ && !(&cnt_eq_q)) ? cnt_eq_q + 1'b1 : cnt_eq_q;
      cnt_lt_d = (dec_q == D_LT && !(&cnt_lt_q)) ? cnt_lt_q + 1'b1 : cnt_lt_q;
      dec_d    = D_EQ;
      state_d  = RECV;
    end
    in_ready_d  = state_d == RECV;
    res_valid_d = state_d == HOLD;
    gt_d        = (state_d == HOLD) && (dec_d == D_GT);
    eq_d        = (state_d == HOLD) && (dec_d == D_EQ);
    lt_d        = (state_d == HOLD) && (dec_d == D_LT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RECV;
      dec_q       <= D_EQ;
      bit_q       <= '0;
      cnt_gt_q    <= '0;
      cnt_eq_q    <= '0;
      cnt_lt_q    <= '0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      bit_q       <= bit_d;
      cnt_gt_q    <= cnt_gt_d;
      cnt_eq_q    <= cnt_eq_d;
      cnt_lt_q    <= cnt_lt_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign cnt_gt    = cnt_gt_q;
  assign cnt_eq    = cnt_eq_q;
  assign cnt_lt    = cnt_lt_q;
endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp: directed checks of two comparator instances,
// u0 (WIDTH=2, CNT_W=8) and u1 (WIDTH=4, CNT_W=2).
module tb_serial_mag_comp;
  logic clk = 0, rst_n;
  logic iv[2], ia[2], ib[2], rr[2], cl[2];
  logic ir[2], rv[2], g[2], e[2], l[2];
  logic [7:0] c0g, c0e, c0l;
  logic [1:0] c1g, c1e, c1l;
  int n = 0, fails = 0;
  int eg, ee, el;

  always #5 clk = ~clk;

  serial_mag_comp #(.WIDTH(2), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(cl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0]), .in_b(ib[0]), .res_valid(rv[0]), .res_ready(rr[0]),
    .gt(g[0]), .eq(e[0]), .lt(l[0]), .cnt_gt(c0g), .cnt_eq(c0e), .cnt_lt(c0l));
  serial_mag_comp #(.WIDTH(4), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(cl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1]), .in_b(ib[1]), .res_valid(rv[1]), .res_ready(rr[1]),
    .gt(g[1]), .eq(e[1]), .lt(l[1]), .cnt_gt(c1g), .cnt_eq(c1e), .cnt_lt(c1l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents bits MSB first, advancing only on cycles where in_ready was high.
  task automatic send(input int k, input int w, input logic [3:0] a, input logic [3:0] b);
    int i = w - 1;
    int guard = 0;
    logic took;
    while (i >= 0 && guard < 50) begin
      iv[k] = 1; ia[k] = a[i]; ib[k] = b[i];
      took = ir[k];
      @(negedge clk);
      if (took) i--;
      guard++;
    end
    iv[k] = 0;
    if (guard >= 50) chk("send_timeout", 32'(guard), 0);
  endtask

  initial begin
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ia[k] = 0; ib[k] = 0; rr[k] = 0; cl[k] = 0;
    end
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", 32'(ir[0]), 1);
    chk("rst_res_valid", 32'(rv[0]), 0);
    chk("rst_gel", {29'd0, g[0], e[0], l[0]}, 0);
    chk("rst_cnt", {c0g, c0e, c0l}, 0);
    rst_n = 1;
    @(negedge clk);
    // T1: A=2, B=1
    send(0, 2, 4'd2, 4'd1);
    chk("t1_res_valid", 32'(rv[0]), 1);
    chk("t1_gel", {29'd0, g[0], e[0], l[0]}, 3'b100);
    chk("t1_in_ready", 32'(ir[0]), 0);
    rr[0] = 1;
    @(negedge clk);
    rr[0] = 0;
    chk("t1_after_ack_rv", 32'(rv[0]), 0);
    chk("t1_after_ack_ir", 32'(ir[0]), 1);
    chk("t1_cnt_gt", 32'(c0g), 1);
    cl[0] = 1; @(negedge clk); cl[0] = 0;
    chk("clr_cnt_gt", 32'(c0g), 0);
    // T2: all 16 combos back to back
    rr[0] = 1;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        send(0, 2, 4'(a), 4'(b));
        chk($sformatf("t2_gel_a%0d_b%0d", a, b), {29'd0, g[0], e[0], l[0]},
            (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001);
      end
    @(negedge clk);
    rr[0] = 0;
    chk("t2_cnt_gt", 32'(c0g), 6);
    chk("t2_cnt_eq", 32'(c0e), 4);
    chk("t2_cnt_lt", 32'(c0l), 6);
    // T3: A=B=3 with gaps, held result
    iv[0] = 1; ia[0] = 1; ib[0] = 1; @(negedge clk);
    iv[0] = 0; ia[0] = 0; ib[0] = 1; @(negedge clk);
    chk("t3_gap_rv", 32'(rv[0]), 0);
    iv[0] = 1; ia[0] = 1; ib[0] = 1; @(negedge clk);
    iv[0] = 1; ia[0] = 1; ib[0] = 0;
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold", {29'd0, rv[0], ir[0], e[0]}, 3'b101);
      @(negedge clk);
    end
    iv[0] = 0;
    rr[0] = 1; @(negedge clk); rr[0] = 0;
    chk("t3_cnt_eq", 32'(c0e), 5);
    chk("t3_cnt_gt", 32'(c0g), 6);
    // T4: early decision on WIDTH=4
    send(1, 4, 4'b0111, 4'b1000);
    chk("t4_gel", {29'd0, g[1], e[1], l[1]}, 3'b001);
    rr[1] = 1; @(negedge clk); rr[1] = 0;
    chk("t4_cnt_lt", 32'(c1l), 1);
    // T5: abort after one bit with clr
    iv[1] = 1; ia[1] = 1; ib[1] = 0; @(negedge clk);
    iv[1] = 0; cl[1] = 1; @(negedge clk); cl[1] = 0;
    chk("t5_clr_ir", 32'(ir[1]), 1);
    chk("t5_clr_cnt_lt", 32'(c1l), 0);
    send(1, 4, 4'b0011, 4'b0011);
    chk("t5_next_frame", {29'd0, rv[1], g[1], e[1], l[1]} , 4'b1010);
    #1 rst_n = 0;
    #1 chk("t5_async_rv", 32'(rv[1]), 0);
    chk("t5_async_ir", 32'(ir[1]), 1);
    @(negedge clk); rst_n = 1;
    chk("t5_rst_cnt0", {c0g, c0e, c0l}, 0);
    @(negedge clk);
    // T6: saturation with CNT_W=2
    rr[1] = 1;
    for (int f = 1; f <= 5; f++) begin
      send(1, 4, 4'b1000, 4'b0000);
      chk($sformatf("t6_gt_%0d", f), 32'(g[1]), 1);
      @(negedge clk);
      eg = (f > 3) ? 3 : f;
      chk($sformatf("t6_cnt_gt_%0d", f), 32'(c1g), 32'(eg));
    end
    rr[1] = 0;
    ee = 0; el = 0;
    chk("t6_cnt_other", {30'd0, c1e} + {30'd0, c1l}, 32'(ee + el));
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
